// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared state encoding, opcode constants, field slices and instruction decode
package alu_seq_pkg;
  typedef enum logic [1:0] {IDLE, SETUP, STROBE, RETIRE} state_t;
  localparam logic [3:0] OPHI_REG = 4'h0;
  localparam logic [3:0] OP_CMP = 4'hB;
  localparam logic [1:0] MUX_IMM = 2'd0;
  localparam logic [1:0] MUX_REGA = 2'd1;
  localparam int OPHI_LSB = 12;
  localparam int RDEST_LSB = 8;
  localparam int OPEXT_LSB = 4;
  localparam int RSRC_LSB = 0;
  typedef struct packed {
    logic [3:0] sel_a;
    logic [3:0] sel_b;
    logic [3:0] sel_in;
    logic [15:0] imm;
    logic [1:0] mux;
    logic [7:0] op;
    logic we;
  } decode_t;
  function automatic decode_t decode(input logic [15:0] inst);
    decode_t d;
    logic [3:0] ophi, rdest, opext, rsrc;
    logic reg_form;
    ophi = inst[OPHI_LSB +: 4];
    rdest = inst[RDEST_LSB +: 4];
    opext = inst[OPEXT_LSB +: 4];
    rsrc = inst[RSRC_LSB +: 4];
    reg_form = ophi == OPHI_REG;
    d.sel_a = reg_form ? rsrc : 4'h0;
    d.sel_b = rdest;
    d.sel_in = rdest;
    d.imm = reg_form ? 16'h0000 : {{8{opext[3]}}, opext, rsrc};
    d.mux = reg_form ? MUX_REGA : MUX_IMM;
    d.op = reg_form ? {4'h0, opext} : {ophi, 4'h0};
    // compares update flags only, so the register file must not be written
    d.we = !(reg_form ? opext == OP_CMP : ophi == OP_CMP);
    return d;
  endfunction
endpackage

// File: rtl/seq_phase_timer.sv
// seq_phase_timer: loadable down-counter that parks at zero and flags expiry
module seq_phase_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             expired
);
  logic [CNT_W-1:0] count;
  assign expired = count == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else count <= load ? value : expired ? count : count - 1'b1;
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: decodes one instruction per handshake and drives a stretched regfile write strobe.
// Optional ALU_SEQ_STEP_EN adds a step input that gates the SETUP -> STROBE transition.
module alu_op_sequencer #(
  parameter int STRETCH = 5,
  parameter int CNT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [15:0] instruction,
  output logic [3:0]  select_a,
  output logic [3:0]  select_b,
  output logic [3:0]  select_in,
  output logic [15:0] immediate,
  output logic [1:0]  mux_select,
  output logic [7:0]  op_code,
  output logic        write_enable,
  output logic        reg_clock,
  output logic        busy,
  output logic        done
`ifdef ALU_SEQ_STEP_EN
  ,
  input  logic        step
`endif
);
  import alu_seq_pkg::*;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(STRETCH - 1);
  state_t state, state_nx;
  decode_t dec, dec_nx;
  logic clk_nx, busy_nx, done_nx, ready_nx;
  logic accept, expired, leave_setup, load;
  assign accept = inst_valid && inst_ready;
  assign load = accept || (state == SETUP && leave_setup);
`ifdef ALU_SEQ_STEP_EN
  logic step_r, step_hit, step_rise;
  assign step_rise = step && !step_r;
  assign leave_setup = expired && (step_hit || step_rise);
  // an edge seen early in SETUP is remembered until the counter expires
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      step_r <= 1'b0;
      step_hit <= 1'b0;
    end else begin
      step_r <= step;
      step_hit <= state == SETUP && !leave_setup && (step_hit || step_rise);
    end
`else
  assign leave_setup = expired;
`endif
  seq_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .load(load),
    .value(RELOAD),
    .expired(expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      dec <= '0;
      reg_clock <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      inst_ready <= 1'b0;
    end else begin
      state <= state_nx;
      dec <= dec_nx;
      reg_clock <= clk_nx;
      busy <= busy_nx;
      done <= done_nx;
      inst_ready <= ready_nx;
    end
  always_comb begin
    state_nx = state == IDLE   ? (accept ? SETUP : IDLE) :
               state == SETUP  ? (leave_setup ? STROBE : SETUP) :
               state == STROBE ? (expired ? RETIRE : STROBE) : IDLE;
    ready_nx = state_nx == IDLE;
  end
  always_comb begin
    dec_nx = accept ? decode(instruction) : dec;
    clk_nx = (state == SETUP && leave_setup) ? 1'b1 : reg_clock;
    busy_nx = accept ? 1'b1 : state == RETIRE ? 1'b0 : busy;
    done_nx = 1'b0;
    if (state == STROBE && expired) begin
      clk_nx = 1'b0;
      dec_nx.we = 1'b0;
      done_nx = 1'b1;
    end
  end
  assign select_a = dec.sel_a;
  assign select_b = dec.sel_b;
  assign select_in = dec.sel_in;
  assign immediate = dec.imm;
  assign mux_select = dec.mux;
  assign op_code = dec.op;
  assign write_enable = dec.we;
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed scoreboard bench for the default (free-running) build
module tb_alu_op_sequencer;
  localparam int S = 5;
  logic clk = 1'b0, rst_n = 1'b0, inst_valid = 1'b0;
  logic [15:0] instruction = 16'h0000;
  logic inst_ready, write_enable, reg_clock, busy, done;
  logic [3:0] select_a, select_b, select_in;
  logic [15:0] immediate;
  logic [1:0] mux_select;
  logic [7:0] op_code;
  typedef struct {
    logic [3:0] a, b, in;
    logic [15:0] imm;
    logic [1:0] mux;
    logic [7:0] op;
    logic we;
  } exp_t;
  exp_t sb[$];
  int compared = 0, mismatched = 0;

  always #5 clk = ~clk;

  alu_op_sequencer #(.STRETCH(S), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .instruction(instruction), .select_a(select_a), .select_b(select_b),
    .select_in(select_in), .immediate(immediate), .mux_select(mux_select),
    .op_code(op_code), .write_enable(write_enable), .reg_clock(reg_clock),
    .busy(busy), .done(done)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    compared++;
    assert (obs === want) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic exp_t model(input logic [15:0] i);
    exp_t e;
    e.b = i[11:8];
    e.in = i[11:8];
    if (i[15:12] == 4'h0) begin
      e.a = i[3:0];
      e.imm = 16'h0000;
      e.mux = 2'd1;
      e.op = {4'h0, i[7:4]};
      e.we = i[7:4] != 4'hB;
    end else begin
      e.a = 4'h0;
      e.imm = i[7] ? {8'hFF, i[7:0]} : {8'h00, i[7:0]};
      e.mux = 2'd0;
      e.op = {i[15:12], 4'h0};
      e.we = i[15:12] != 4'hB;
    end
    return e;
  endfunction

  task automatic check_fields(input string tag, input exp_t e);
    check({tag, ".select_a"}, select_a, e.a);
    check({tag, ".select_b"}, select_b, e.b);
    check({tag, ".select_in"}, select_in, e.in);
    check({tag, ".immediate"}, immediate, e.imm);
    check({tag, ".mux_select"}, mux_select, e.mux);
    check({tag, ".op_code"}, op_code, e.op);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!inst_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready", inst_ready, 1);
  endtask

  // accept one instruction and check every cycle up to the next ready
  task automatic run_inst(input logic [15:0] i);
    exp_t e, f;
    wait_ready();
    inst_valid = 1'b1;
    instruction = i;
    e = model(i);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    inst_valid = 1'b0;
    instruction = ~i;
    check_fields("decode", e);
    for (int k = 1; k <= 2 * S + 2; k++) begin
      check($sformatf("reg_clock@%0d", k), reg_clock, k > S && k <= 2 * S);
      check($sformatf("done@%0d", k), done, k == 2 * S + 1);
      check($sformatf("busy@%0d", k), busy, k <= 2 * S + 1);
      check($sformatf("write_enable@%0d", k), write_enable, e.we && k <= 2 * S);
      check($sformatf("inst_ready@%0d", k), inst_ready, k == 2 * S + 2);
      if (done && sb.size() > 0) begin
        f = sb.pop_front();
        check_fields("retire", f);
      end
      if (k < 2 * S + 2) @(negedge clk);
    end
    check("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    exp_t f;
    int cyc, last, accepts;
    @(negedge clk);
    check("rst.inst_ready", inst_ready, 0);
    check("rst.reg_clock", reg_clock, 0);
    check("rst.busy", busy, 0);
    check("rst.op_code", op_code, 0);
    check("rst.immediate", immediate, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst.inst_ready", inst_ready, 1);
    run_inst(16'h0261);
    run_inst(16'hD0F9);
    run_inst(16'h03B4);
    run_inst(16'h7B05);
    run_inst(16'hB380);
    run_inst(16'h0F0F);
    // valid held high with a changing instruction: only handshake values count
    inst_valid = 1'b1;
    cyc = 0;
    last = -1;
    accepts = 0;
    while ((inst_valid || sb.size() > 0) && cyc < 200) begin
      instruction = 16'($urandom);
      if (done && sb.size() > 0) begin
        f = sb.pop_front();
        check_fields("held_valid", f);
      end
      if (inst_ready) begin
        if (accepts < 3) begin
          if (last >= 0) check("accept_spacing", cyc - last, 2 * S + 2);
          last = cyc;
          sb.push_back(model(instruction));
          accepts++;
        end else inst_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check("held_valid_timeout", cyc < 200, 1);
    check("held_valid_accepts", accepts, 3);
    // reset in the middle of the strobe phase drops the instruction
    wait_ready();
    inst_valid = 1'b1;
    instruction = 16'h0261;
    @(posedge clk);
    @(negedge clk);
    inst_valid = 1'b0;
    repeat (S + 1) @(negedge clk);
    check("mid.reg_clock", reg_clock, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst.reg_clock", reg_clock, 0);
    check("mid_rst.write_enable", write_enable, 0);
    check("mid_rst.busy", busy, 0);
    check("mid_rst.inst_ready", inst_ready, 0);
    check("mid_rst.select_b", select_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel.inst_ready", inst_ready, 1);
    check("rel.reg_clock", reg_clock, 0);
    check("rel.done", done, 0);
    check("rel.op_code", op_code, 0);
    check("rel.mux_select", mux_select, 0);
    run_inst(16'h0512);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
